dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_arbiter_if.sv | 55 +++++
 rtl/dmem_grant_mux.sv | 63 ++++++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Brief    : Shared types and defaults for the data-memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;
    localparam int c_data_w   = 32;
    localparam int c_addr_w   = 8;
    localparam int c_word_lsb = 2;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : CPU, debug, clear-control and memory-side signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W = c_data_w
);
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              dbg_valid;
    logic              dbg_ready;
    logic              dbg_we;
    logic [31:0]       dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ready, dbg_rvalid, dbg_rdata,
        input  clr_start,
        output clr_busy, clr_done,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ready, dbg_rvalid, dbg_rdata,
        output clr_start,
        input  clr_busy, clr_done,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_grant_mux.sv
`default_nettype none
// ============================================================================
// Module   : dmem_grant_mux
// Brief    : Combinational grant decision and memory-port steering.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_grant_mux
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W       = c_data_w,
    parameter int ADDR_W       = c_addr_w,
    parameter int STARVE_LIMIT = 4,
    parameter int STARVE_W     = $clog2(STARVE_LIMIT + 1)
) (
    input  wire logic                i_en,
    input  wire logic                i_clear,
    input  wire logic [ADDR_W-1:0]   i_clr_cnt,
    input  wire logic [STARVE_W-1:0] i_starve_cnt,
    input  wire logic                i_cpu_req,
    input  wire logic                i_cpu_we,
    input  wire logic [31:0]         i_cpu_addr,
    input  wire logic [DATA_W-1:0]   i_cpu_wdata,
    input  wire logic                i_dbg_valid,
    input  wire logic                i_dbg_we,
    input  wire logic [31:0]         i_dbg_addr,
    input  wire logic [DATA_W-1:0]   i_dbg_wdata,
    output logic [31:0]              o_mem_addr,
    output logic [DATA_W-1:0]        o_mem_wdata,
    output logic                     o_mem_we,
    output logic                     o_dbg_grant,
    output logic                     o_cpu_stall
);
    logic w_dbg_win;

    always_comb begin
        w_dbg_win   = i_dbg_valid &&
                      (!i_cpu_req || i_starve_cnt == STARVE_W'(STARVE_LIMIT));
        o_mem_addr  = i_cpu_addr;
        o_mem_wdata = i_cpu_wdata;
        o_mem_we    = 1'b0;
        o_dbg_grant = 1'b0;
        o_cpu_stall = 1'b0;
        // Everything stays quiet while reset is held.
        if (i_en) begin
            if (i_clear) begin
                o_mem_addr  = {{(32-ADDR_W-c_word_lsb){1'b0}}, i_clr_cnt,
                               {c_word_lsb{1'b0}}};
                o_mem_wdata = '0;
                o_mem_we    = 1'b1;
                o_cpu_stall = i_cpu_req;
            end else if (w_dbg_win) begin
                o_mem_addr  = i_dbg_addr;
                o_mem_wdata = i_dbg_wdata;
                o_mem_we    = i_dbg_we;
                o_dbg_grant = 1'b1;
                o_cpu_stall = i_cpu_req;
            end else if (i_cpu_req) begin
                o_mem_we    = i_cpu_we;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : CPU/debug data-memory port arbiter with hardware clear pass.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W       = c_data_w,
    parameter int ADDR_W       = c_addr_w,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    dmem_arbiter_if.slave   bus
);
    localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [ADDR_W-1:0]       r_clr_cnt;
    logic [c_starve_w-1:0]   r_starve_cnt;
    logic                    r_dbg_rvalid;
    logic [DATA_W-1:0]       r_dbg_rdata;
    logic                    r_clr_done;
    logic                    w_clr_last;
    logic                    w_dbg_grant;
    logic                    w_dbg_read;

    assign w_clr_last = (r_state == CLEAR) && (&r_clr_cnt);
    assign w_dbg_read = w_dbg_grant && !bus.dbg_we;

    dmem_grant_mux #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (STARVE_LIMIT),
        .STARVE_W     (c_starve_w)
    ) u_grant_mux (
        .i_en         (rst_n),
        .i_clear      (r_state == CLEAR),
        .i_clr_cnt    (r_clr_cnt),
        .i_starve_cnt (r_starve_cnt),
        .i_cpu_req    (bus.cpu_req),
        .i_cpu_we     (bus.cpu_we),
        .i_cpu_addr   (bus.cpu_addr),
        .i_cpu_wdata  (bus.cpu_wdata),
        .i_dbg_valid  (bus.dbg_valid),
        .i_dbg_we     (bus.dbg_we),
        .i_dbg_addr   (bus.dbg_addr),
        .i_dbg_wdata  (bus.dbg_wdata),
        .o_mem_addr   (bus.mem_addr),
        .o_mem_wdata  (bus.mem_wdata),
        .o_mem_we     (bus.mem_we),
        .o_dbg_grant  (w_dbg_grant),
        .o_cpu_stall  (bus.cpu_stall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (bus.clr_start) w_state_nxt = CLEAR;
            CLEAR:   if (w_clr_last)    w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr_cnt    <= '0;
            r_starve_cnt <= '0;
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= '0;
            r_clr_done   <= 1'b0;
        end else begin
            r_clr_done   <= w_clr_last;
            r_dbg_rvalid <= w_dbg_read;
            if (w_dbg_read) begin
                r_dbg_rdata <= bus.mem_rdata;
            end
            // Natural wrap after word DEPTH-1 leaves the counter at 0 for the next pass.
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
            if (r_state == RUN) begin
                if (w_dbg_grant || !bus.dbg_valid) begin
                    r_starve_cnt <= '0;
                end else if (r_starve_cnt != c_starve_w'(STARVE_LIMIT)) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dbg_ready  = w_dbg_grant;
    assign bus.dbg_rvalid = r_dbg_rvalid;
    assign bus.dbg_rdata  = r_dbg_rdata;
    assign bus.clr_busy   = rst_n && (r_state == CLEAR);
    assign bus.clr_done   = r_clr_done;
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a 256-word memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam logic [31:0] c_beef = 32'hDEAD_BEEF;

    typedef struct {
        bit          cr, cw;
        logic [31:0] ca, cd;
        bit          dv, dw;
        logic [31:0] da, dd;
        bit          e_we;
        logic [31:0] e_addr, e_wdata;
        bit          e_stall, e_ready, e_rvalid;
        logic [31:0] e_rdata;
        bit          chk_crd;
        logic [31:0] e_crd;
    } vec_t;

    bit   clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(32)) bus ();

    dmem_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (8),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    function automatic vec_t mk(input int cr, cw, input logic [31:0] ca, cd,
                                input int dv, dw, input logic [31:0] da, dd,
                                input int e_we, input logic [31:0] e_addr, e_wdata,
                                input int e_stall, e_ready, e_rvalid,
                                input logic [31:0] e_rdata,
                                input int chk_crd, input logic [31:0] e_crd);
        vec_t v;
        v.cr = (cr != 0);  v.cw = (cw != 0);  v.ca = ca;  v.cd = cd;
        v.dv = (dv != 0);  v.dw = (dw != 0);  v.da = da;  v.dd = dd;
        v.e_we = (e_we != 0);  v.e_addr = e_addr;  v.e_wdata = e_wdata;
        v.e_stall = (e_stall != 0);  v.e_ready = (e_ready != 0);
        v.e_rvalid = (e_rvalid != 0);  v.e_rdata = e_rdata;
        v.chk_crd = (chk_crd != 0);  v.e_crd = e_crd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_addr = '0;  bus.cpu_wdata = '0;
        bus.dbg_valid = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0;  bus.dbg_wdata = '0;
        bus.clr_start = 1'b0;
    endtask

    task automatic dbg_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        idle();
        bus.dbg_valid = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = a; bus.dbg_wdata = d;
        #2;
        chk($sformatf("preload ready %h", a), 32'(bus.dbg_ready), 32'd1);
    endtask

    task automatic cpu_ld(input logic [31:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        idle();
        bus.cpu_req = 1'b1; bus.cpu_addr = a;
        #2;
        chk(name, bus.cpu_rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int bad;
        int seen;

        // Directed vectors: one per cycle, in order (starve counter carries state).
        tbl.push_back(mk(1,1,'h10,c_beef, 0,0,0,0,      1,'h10,c_beef,   0,0,0,0,       0,0));
        tbl.push_back(mk(1,0,'h10,0,      0,0,0,0,      0,'h10,0,        0,0,0,0,       1,c_beef));
        tbl.push_back(mk(0,0,'h20,0,      0,0,0,0,      0,'h20,0,        0,0,0,0,       0,0));
        tbl.push_back(mk(0,0,'h20,0,      1,1,'h3FC,'h55, 1,'h3FC,'h55,  0,1,0,0,       0,0));
        tbl.push_back(mk(0,0,'h20,0,      1,0,'h3FC,0,  0,'h3FC,0,       0,1,0,0,       1,'h55));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,      0,0,0,           0,0,1,'h55,    0,0));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,      0,0,0,           0,0,0,0,       0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,0,'h14,0,  1,0,'h10,0,   0,'h14,0,        0,0,0,0,       0,0));
        tbl.push_back(mk(1,0,'h14,0,      1,0,'h10,0,   0,'h10,0,        1,1,0,0,       1,c_beef));
        tbl.push_back(mk(1,0,'h14,0,      0,0,0,0,      0,'h14,0,        0,0,1,c_beef,  0,0));
        tbl.push_back(mk(1,0,'h14,0,      1,0,'h10,0,   0,'h14,0,        0,0,0,0,       0,0));
        tbl.push_back(mk(1,0,'h14,0,      0,0,0,0,      0,'h14,0,        0,0,0,0,       0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,0,'h14,0,  1,1,'h40,'h1234, 0,'h14,0,     0,0,0,0,       0,0));
        tbl.push_back(mk(1,0,'h14,0,      1,1,'h40,'h1234, 1,'h40,'h1234, 1,1,0,0,      0,0));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,      0,0,0,           0,0,0,0,       0,0));
        tbl.push_back(mk(0,0,0,0,         1,0,'h40,0,   0,'h40,0,        0,1,0,0,       1,'h1234));
        tbl.push_back(mk(0,0,0,0,         1,0,'h10,0,   0,'h10,0,        0,1,1,'h1234,  0,0));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,      0,0,0,           0,0,1,c_beef,  0,0));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,      0,0,0,           0,0,0,0,       0,0));
        tbl.push_back(mk(1,0,'hFFFF0010,0, 0,0,0,0,     0,'hFFFF0010,0,  0,0,0,0,       1,c_beef));

        // Reset: outputs forced low even with every request asserted.
        idle();
        rst_n = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.dbg_valid = 1'b1; bus.dbg_we = 1'b1;
        #2;
        chk("rst mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst dbg_ready", 32'(bus.dbg_ready), 32'd0);
        chk("rst cpu_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst clr_busy",  32'(bus.clr_busy),  32'd0);
        @(negedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #2;
        chk("rst dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("rst dbg_rdata",  bus.dbg_rdata,       32'd0);
        chk("rst clr_done",   32'(bus.clr_done),   32'd0);

        foreach (tbl[i]) begin
            @(negedge clk);
            bus.cpu_req = tbl[i].cr; bus.cpu_we = tbl[i].cw;
            bus.cpu_addr = tbl[i].ca; bus.cpu_wdata = tbl[i].cd;
            bus.dbg_valid = tbl[i].dv; bus.dbg_we = tbl[i].dw;
            bus.dbg_addr = tbl[i].da; bus.dbg_wdata = tbl[i].dd;
            #2;
            chk($sformatf("v%0d mem_we", i),     32'(bus.mem_we),     32'(tbl[i].e_we));
            chk($sformatf("v%0d mem_addr", i),   bus.mem_addr,        tbl[i].e_addr);
            chk($sformatf("v%0d cpu_stall", i),  32'(bus.cpu_stall),  32'(tbl[i].e_stall));
            chk($sformatf("v%0d dbg_ready", i),  32'(bus.dbg_ready),  32'(tbl[i].e_ready));
            chk($sformatf("v%0d dbg_rvalid", i), 32'(bus.dbg_rvalid), 32'(tbl[i].e_rvalid));
            if (tbl[i].e_we)     chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, tbl[i].e_wdata);
            if (tbl[i].e_rvalid) chk($sformatf("v%0d dbg_rdata", i), bus.dbg_rdata, tbl[i].e_rdata);
            if (tbl[i].chk_crd)  chk($sformatf("v%0d cpu_rdata", i), bus.cpu_rdata, tbl[i].e_crd);
        end

        // Full clear pass started alongside a granted debug read.
        dbg_wr(32'h000, 32'h1111_1111);
        dbg_wr(32'h200, 32'h2222_2222);
        dbg_wr(32'h3FC, 32'h3333_3333);
        dbg_wr(32'h320, 32'hC8C8_C8C8);
        @(negedge clk);
        idle();
        bus.clr_start = 1'b1;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 32'h200;
        #2;
        chk("coinc dbg_ready", 32'(bus.dbg_ready), 32'd1);
        chk("coinc clr_busy",  32'(bus.clr_busy),  32'd0);
        @(negedge clk);
        bus.clr_start = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h14;
        #2;
        chk("coinc dbg_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        chk("coinc dbg_rdata",  bus.dbg_rdata,       32'h2222_2222);
        n = 0;
        bad = 0;
        while (bus.clr_busy && n < 400) begin
            if (bus.mem_addr !== 32'(n) << 2 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'd0 ||
                bus.dbg_ready !== 1'b0 || bus.cpu_stall !== (n < 20) || bus.clr_done !== 1'b0)
                bad++;
            n++;
            @(negedge clk);
            bus.clr_start = (n == 10);
            if (n == 20) begin
                bus.cpu_req = 1'b0;
                bus.dbg_valid = 1'b0;
            end
            #2;
        end
        chk("clear cycles",      n,   256);
        chk("clear sweep errs",  bad, 0);
        chk("clear done pulse",  32'(bus.clr_done), 32'd1);
        @(negedge clk);
        #2;
        chk("clear done single", 32'(bus.clr_done), 32'd0);
        cpu_ld(32'h000, 32'd0, "cleared word0");
        cpu_ld(32'h200, 32'd0, "cleared word128");
        cpu_ld(32'h3FC, 32'd0, "cleared word255");
        cpu_ld(32'h320, 32'd0, "cleared word200");

        // Reset lands on clear cycle 100: pass aborts, upper words survive.
        dbg_wr(32'h320, 32'hC8C8_C8C8);
        dbg_wr(32'h0C8, 32'h5050_5050);
        dbg_wr(32'h190, 32'h6464_6464);
        @(negedge clk);
        idle();
        bus.clr_start = 1'b1;
        @(negedge clk);
        bus.clr_start = 1'b0;
        #2;
        n = 0;
        while (bus.clr_busy && n < 100) begin
            n++;
            @(negedge clk);
            #2;
        end
        chk("abort at cycle", n, 100);
        chk("abort mem_addr", bus.mem_addr, 32'h190);
        rst_n = 1'b0;
        #1;
        chk("abort busy in rst", 32'(bus.clr_busy), 32'd0);
        chk("abort we in rst",   32'(bus.mem_we),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("abort busy after", 32'(bus.clr_busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.clr_done !== 1'b0 || bus.clr_busy !== 1'b0) seen++;
            @(negedge clk);
            #2;
        end
        chk("abort no done", seen, 0);
        cpu_ld(32'h320, 32'hC8C8_C8C8, "abort word200 kept");
        cpu_ld(32'h0C8, 32'd0,         "abort word50 cleared");
        cpu_ld(32'h190, 32'h6464_6464, "abort word100 kept");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
